trian_frame_packer: RTL
=======================

# trian_frame_packer

Downstream consumer of the triangle data generator in the SDRAM readout path. On a sample strobe it captures the full multi-channel sample vector (BATCHNUM channels × BATCHSIZE bits). It then streams the vector as a framed sequence of WORDW-bit words into the SDRAM write FIFO: header, data words, XOR checksum trailer. Flow control uses the FIFO's ready/not-full signal. Samples arriving while a frame is in flight are dropped and counted.

## Interface
- BATCHSIZE, 10, bits per channel.
- BATCHNUM, 32, channel count.
- WORDW, 16, output word width. BATCHSIZE*BATCHNUM must be an integer multiple of WORDW.
- NWORDS, BATCHSIZE*BATCHNUM/WORDW (=20), data words per frame. Derived; not overridden.
- HDR_TAG, 4'hA, upper nibble of the header word.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DIN  in  BATCHSIZE*BATCHNUM  sample vector from the generator.
- DIN_VALID  in  1  one-cycle strobe: DIN is valid this cycle.
- WR_READY  in  1  FIFO can accept a word this cycle (i.e. not full).
- WR_EN  out  1  word write strobe to the FIFO.
- WR_DATA  out  WORDW  word being written.
- BUSY  out  1  frame in flight (state ≠ IDLE).
- FRAME_CNT  out  16  completed frames, wraps modulo 2^16.
- DROP_CNT  out  16  dropped samples, saturates at 16'hFFFF.
- OVERRUN  out  1  sticky; set on the first drop, cleared only by RST.

## Operation
- State machine states: IDLE, HEADER, DATA, TRAILER.
- Shadow register SHR (BATCHSIZE*BATCHNUM bits), word index IDX (0..NWORDS-1), checksum register CHK (WORDW bits).
- **IDLE**
  - On DIN_VALID: SHR <= DIN, CHK <= 0, IDX <= 0, go to HEADER.
- **WR_EN rule (all states)**
  - WR_EN = (state ≠ IDLE) & WR_READY. Combinational from the state register and WR_READY.
  - A state "advances" only in a cycle where WR_EN = 1. Otherwise it holds, with WR_DATA stable.
- **HEADER**
  - WR_DATA = {HDR_TAG, FRAME_CNT[11:0]}.
  - On advance, go to DATA.
- **DATA**
  - WR_DATA = SHR[IDX*WORDW +: WORDW]. Word 0 holds channel 0's LSBs.
  - On advance: CHK <= CHK ^ WR_DATA, IDX <= IDX+1.
  - When IDX = NWORDS-1 advances, go to TRAILER.
- **TRAILER**
  - WR_DATA = CHK, the XOR of all NWORDS data words.
  - On advance: FRAME_CNT <= FRAME_CNT+1.
  - If DIN_VALID is also high that cycle, capture DIN as in IDLE and go to HEADER (back-to-back accepted). Otherwise go to IDLE.
- **Drops**
  - DIN_VALID while in HEADER, DATA, or in TRAILER without an advance: sample dropped.
  - SHR is unchanged, DROP_CNT increments (saturating), OVERRUN <= 1.
- **Data integrity**
  - DIN changes after capture have no effect on the frame in flight.
- **Reset mid-frame**
  - Frame abandoned, nothing further written, all state cleared.
- **Unreachable states**
  - Any unreachable state encoding returns to IDLE.

## Timing
- Reset values: WR_EN=0, WR_DATA=0, BUSY=0, FRAME_CNT=0, DROP_CNT=0, OVERRUN=0, state=IDLE, SHR=0, CHK=0, IDX=0.
- In IDLE, WR_DATA holds its last value (0 after reset).
- Latency: DIN_VALID at cycle n (IDLE) → header on WR_DATA and BUSY=1 at cycle n+1. WR_EN at n+1 if WR_READY.
- Frame length: 1 + NWORDS + 1 = 22 words. Minimum 22 cycles with WR_READY held high.
- Sustained rate: one DIN_VALID every 22 cycles is lossless when the strobe coincides with, or follows, the trailer advance.
- WR_READY low stalls the current word indefinitely with no loss. WR_EN deasserts the same cycle WR_READY drops.
- FRAME_CNT updates the cycle after the trailer is written. The next header uses the updated value.

## Test plan
- **Single frame.** After RST, DIN = 0 except channel 0 = 10'h3FF; one DIN_VALID; WR_READY=1.
  - Expect 22 consecutive writes: 16'hA000, 16'h03FF, nineteen 16'h0000, trailer 16'h03FF.
  - Then FRAME_CNT=1, BUSY=0.
- **All-ones.** DIN all ones.
  - Expect data words all 16'hFFFF and trailer 16'h0000 (even count of 20).
  - Header of this second frame = 16'hA001.
- **Backpressure.** WR_READY toggled 0/1 every cycle during a frame.
  - Expect exactly 22 writes, in order, identical to the unstalled case.
  - WR_EN never high while WR_READY=0.
- **Drop.** DIN_VALID pulsed at header+5 and at header+10 during a frame.
  - Expect the frame content unchanged, DROP_CNT=2, OVERRUN=1 held until RST.
- **Back-to-back.** DIN_VALID coincident with the trailer write.
  - Expect the header at the next cycle, no drop, FRAME_CNT increments twice over the two frames.
- **Reset mid-frame.** Assert RST after data word 7.
  - Expect WR_EN=0 immediately, all outputs at reset values.
  - A new DIN_VALID afterwards gives header 16'hA000.

Source files
------------

// File: rtl/trian_frame_packer.sv
// trian_frame_packer: captures a multi-channel sample vector and streams it as a
// header / data / XOR-checksum frame into a FIFO, dropping samples that arrive mid-frame.
module trian_frame_packer #(
  parameter int BATCHSIZE = 10,
  parameter int BATCHNUM = 32,
  parameter int WORDW = 16,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [BATCHSIZE*BATCHNUM-1:0] DIN,
  input  logic                          DIN_VALID,
  input  logic                          WR_READY,
  output logic                          WR_EN,
  output logic [WORDW-1:0]              WR_DATA,
  output logic                          BUSY,
  output logic [15:0]                   FRAME_CNT,
  output logic [15:0]                   DROP_CNT,
  output logic                          OVERRUN
);
  localparam int VW = BATCHSIZE * BATCHNUM;
  localparam int NWORDS = VW / WORDW;
  localparam int IW = $clog2(NWORDS);
  typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] shr_q, shr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WORDW-1:0] chk_q, chk_d, hold_q, hold_d, word;
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic overrun_q, overrun_d, adv, capture, drop, last;
  assign adv = (state_q != IDLE) & WR_READY;
  assign capture = DIN_VALID & ((state_q == IDLE) | ((state_q == TRAILER) & adv));
  assign drop = DIN_VALID & ~capture;
  assign last = idx_q == IW'(NWORDS - 1);
  assign word = state_q == HEADER ? {HDR_TAG, frame_cnt_q[11:0]} :
                state_q == DATA ? shr_q[int'(idx_q)*WORDW +: WORDW] : chk_q;
  always_comb begin
    state_d = state_q;
    shr_d = shr_q;
    idx_d = idx_q;
    chk_d = chk_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overrun_d = overrun_q;
    hold_d = state_q != IDLE ? word : hold_q;
    case (state_q)
      IDLE: state_d = DIN_VALID ? HEADER : IDLE;
      HEADER: state_d = adv ? DATA : HEADER;
      DATA: begin
        if (idx_q > IW'(NWORDS - 1)) state_d = IDLE;
        else if (adv) begin
          chk_d = chk_q ^ word;
          idx_d = last ? '0 : idx_q + 1'b1;
          state_d = last ? TRAILER : DATA;
        end
      end
      TRAILER: begin
        if (adv) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d = DIN_VALID ? HEADER : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      shr_d = DIN;
      chk_d = '0;
      idx_d = '0;
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q == 16'hFFFF ? drop_cnt_q : drop_cnt_q + 16'd1;
      overrun_d = 1'b1;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shr_q <= '0;
      idx_q <= '0;
      chk_q <= '0;
      hold_q <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shr_q <= shr_d;
      idx_q <= idx_d;
      chk_q <= chk_d;
      hold_q <= hold_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overrun_q <= overrun_d;
    end
  end
  assign WR_EN = adv;
  assign WR_DATA = state_q == IDLE ? hold_q : word;
  assign BUSY = state_q != IDLE;
  assign FRAME_CNT = frame_cnt_q;
  assign DROP_CNT = drop_cnt_q;
  assign OVERRUN = overrun_q;
endmodule
